dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 512, giving the byte capacity of the data store (power of two, at least 8).
REQ-002 SHALL have parameter LATENCY, default 2, giving the wait cycles between request acceptance and response (range 0..15).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is asynchronous and active-low (0 = reset asserted).
REQ-005 SHALL have port req_valid, input, 1 bit, meaning the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit, meaning the responder accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 64 bits, the byte address.
REQ-009 SHALL have port req_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
REQ-010 SHALL have port req_wdata, input, 64 bits, the store data, with the active bytes in the low end.
REQ-011 SHALL have port resp_valid, output, 1 bit, meaning a response is presented.
REQ-012 SHALL have port resp_ready, input, 1 bit, meaning the initiator takes the response.
REQ-013 SHALL have port resp_rdata, output, 64 bits, the load data zero-extended; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit, which flags a misaligned or out-of-range access.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle with req_valid & req_ready.
REQ-017 SHALL capture write, addr, size and wdata on acceptance and ignore request inputs in all other states.
REQ-018 On acceptance, SHALL go to WAIT and load a latency counter with LATENCY, or go directly to RESP when LATENCY=0.
REQ-019 In WAIT, SHALL decrement the counter each cycle and enter RESP on the cycle after the counter reaches 1.
REQ-020 SHALL make total latency from the acceptance edge to the first resp_valid=1 cycle equal to LATENCY+1 cycles.
REQ-021 SHALL perform the memory access (store update or load sample) exactly once, on the edge entering RESP.
REQ-022 SHALL hold resp_valid=1 with stable resp_rdata and resp_err in RESP until resp_ready=1.
REQ-023 SHALL return to IDLE on the edge where resp_valid & resp_ready; req_ready SHALL rise the following cycle (no same-cycle back-to-back acceptance).
REQ-024 SHALL store data little-endian: byte k of a 2^size-byte access maps to address addr+k.
REQ-025 SHALL flag misalignment (addr mod 2^size != 0) and set resp_err=1 with no memory update.
REQ-026 SHALL flag out-of-range accesses (addr+2^size > MEM_BYTES, computed without 64-bit wrap) and set resp_err=1 with no memory update.
REQ-027 SHALL write only the 2^size addressed bytes on a store; other bytes remain unchanged.
REQ-028 SHALL leave resp_rdata bits above 8*2^size at zero; sign extension is the initiator's responsibility.

Reset
REQ-029 While reset=0, SHALL force state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0 and req_ready=0 asynchronously.
REQ-030 SHALL assert req_ready=1 from the first clk edge after reset deasserts.
REQ-031 Reset asserted in WAIT or RESP SHALL abandon the in-flight access; a store not yet committed SHALL NOT update memory.
REQ-032 Memory contents SHALL NOT be cleared by reset; the store powers up as all zeros.

Verification
REQ-033 With LATENCY=2: store dword 0x1122334455667788 to addr 0x10, then load dword from 0x10 -> resp_valid 3 cycles after each acceptance, resp_rdata=0x1122334455667788, resp_err=0.
REQ-034 Following REQ-033: load byte from 0x13 -> resp_rdata=0x55; load half from 0x12 -> resp_rdata=0x5566; store byte 0xAB to 0x10, then load dword from 0x10 -> 0x11223344556677AB.
REQ-035 Load word from 0x11 -> resp_err=1 and resp_rdata=0; load dword from MEM_BYTES-4 -> resp_err=1; memory unchanged afterwards.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable for all 5 cycles, req_ready=0 throughout, with a single completion when resp_ready rises.
REQ-037 Assert reset=0 mid-clock during WAIT of a store to 0x20 -> outputs clear immediately; a subsequent load of 0x20 returns 0.
REQ-038 With LATENCY=0: accept a load -> resp_valid is high the cycle after acceptance.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-addressed data memory responder with fixed access latency
// One request in flight; the access is performed on the edge entering RESP.
module dmem_responder #(
  parameter int MEM_BYTES = 512,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        ready_en;
  logic        accept, enter_resp;

  logic        cap_write;
  logic [63:0] cap_addr;
  logic [1:0]  cap_size;
  logic [63:0] cap_wdata;

  logic        acc_write;
  logic [63:0] acc_addr;
  logic [1:0]  acc_size;
  logic [63:0] acc_wdata;
  logic [3:0]  acc_nbytes;
  logic [64:0] acc_end;
  logic        acc_misaligned, acc_oor, acc_err;
  logic [63:0] acc_rdata;

  logic [7:0]  mem [MEM_BYTES];

  assign accept     = req_valid & req_ready;
  assign enter_resp = (state_next == RESP) && (state != RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt <= 4'd1) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && ready_en;
    resp_valid = (state == RESP);
  end

  // With LATENCY=0 the access happens on the acceptance edge, before capture lands.
  always_comb begin
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_size  = req_size;
      acc_wdata = req_wdata;
    end else begin
      acc_write = cap_write;
      acc_addr  = cap_addr;
      acc_size  = cap_size;
      acc_wdata = cap_wdata;
    end
  end

  always_comb begin
    acc_nbytes = 4'd1 << acc_size;
    case (acc_size)
      2'd0:    acc_misaligned = 1'b0;
      2'd1:    acc_misaligned = acc_addr[0];
      2'd2:    acc_misaligned = |acc_addr[1:0];
      default: acc_misaligned = |acc_addr[2:0];
    endcase
    acc_end = {1'b0, acc_addr} + {61'b0, acc_nbytes};
    acc_oor = acc_end > 65'(MEM_BYTES);
    acc_err = acc_misaligned | acc_oor;
  end

  always_comb begin
    acc_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < acc_nbytes) acc_rdata[8*k +: 8] = mem[acc_addr[AW-1:0] + AW'(k)];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      ready_en   <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_size   <= '0;
      cap_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_size  <= req_size;
        cap_wdata <= req_wdata;
        cnt       <= 4'(LATENCY);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_write || acc_err) ? 64'd0 : acc_rdata;
      end
    end
  end

  // Storage is not reset; an abandoned access never reaches enter_resp.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_write && !acc_err) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < acc_nbytes) mem[acc_addr[AW-1:0] + AW'(k)] <= acc_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int MEM = 512;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [63:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  req_size;
  logic        req_valid0, req_ready0, req_write0, resp_valid0, resp_ready0, resp_err0;
  logic [63:0] req_addr0, req_wdata0, resp_rdata0;
  logic [1:0]  req_size0;

  int n_checks = 0;
  int n_fail   = 0;
  byte unsigned ref_mem [MEM];

  always #5 clk = ~clk;

  dmem_responder #(.MEM_BYTES(MEM), .LATENCY(LAT)) dut (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.MEM_BYTES(MEM), .LATENCY(0)) dut0 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_addr(req_addr0), .req_size(req_size0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void timed_out(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // Called at a negedge; returns at the negedge after completion with req_valid low.
  task automatic xact(input string name, input logic w, input logic [63:0] a, input logic [1:0] s,
                      input logic [63:0] d, input logic [63:0] exp_rd, input logic exp_err,
                      input int hold);
    int n;
    int lat;
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = d;
    resp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin timed_out({name, "_accept"}); req_valid = 1'b0; return; end
    @(negedge clk);
    // Keep a garbage store request on the bus; it must be ignored until IDLE.
    req_write = 1'b1;
    req_addr  = {55'd0, 9'($urandom)};
    req_size  = 2'($urandom);
    req_wdata = {$urandom, $urandom};
    lat = 1;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!resp_valid) begin timed_out({name, "_resp"}); req_valid = 1'b0; resp_ready = 1'b1; return; end
    check({name, "_lat"}, 64'(lat), 64'(LAT + 1));
    check({name, "_rdata"}, resp_rdata, exp_rd);
    check({name, "_err"}, 64'(resp_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold_valid"}, 64'(resp_valid), 64'd1);
      check({name, "_hold_rdata"}, resp_rdata, exp_rd);
      check({name, "_hold_req_ready"}, 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check({name, "_done_valid"}, 64'(resp_valid), 64'd0);
    check({name, "_done_ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic xact0(input string name, input logic w, input logic [63:0] a, input logic [1:0] s,
                       input logic [63:0] d, input logic [63:0] exp_rd, input logic exp_err);
    int n;
    req_valid0 = 1'b1; req_write0 = w; req_addr0 = a; req_size0 = s; req_wdata0 = d;
    resp_ready0 = 1'b1;
    n = 0;
    while (!req_ready0 && n < 50) begin @(negedge clk); n++; end
    if (!req_ready0) begin timed_out({name, "_accept"}); req_valid0 = 1'b0; return; end
    @(negedge clk);
    req_valid0 = 1'b0;
    check({name, "_valid"}, 64'(resp_valid0), 64'd1);
    check({name, "_rdata"}, resp_rdata0, exp_rd);
    check({name, "_err"}, 64'(resp_err0), 64'(exp_err));
    @(negedge clk);
    check({name, "_done"}, 64'(resp_valid0), 64'd0);
  endtask

  task automatic zero_fill();
    for (int i = 0; i < MEM / 8; i++) xact("fill", 1'b1, 64'(i * 8), 2'd3, 64'd0, 64'd0, 1'b0, 0);
    for (int i = 0; i < MEM; i++) ref_mem[i] = 8'd0;
  endtask

  task automatic reset_mid_cycle(input string name);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_rv"}, 64'(resp_valid), 64'd0);
    check({name, "_rdata"}, resp_rdata, 64'd0);
    check({name, "_err"}, 64'(resp_err), 64'd0);
    check({name, "_rr"}, 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check({name, "_rr_release"}, 64'(req_ready), 64'd0);
    @(negedge clk);
    check({name, "_rr_after_edge"}, 64'(req_ready), 64'd1);
  endtask

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [1:0]  s;
    logic [63:0] d;
    logic [63:0] rd;
    logic        e;
  } vec_t;

  vec_t vt [17];

  initial begin
    logic [63:0] a, d, exp_rd;
    logic [1:0]  s;
    logic        w, e;
    int          nb;

    vt[0]  = '{1'b1, 64'h10,  2'd3, 64'h1122334455667788, 64'h0, 1'b0};
    vt[1]  = '{1'b0, 64'h10,  2'd3, 64'h0, 64'h1122334455667788, 1'b0};
    vt[2]  = '{1'b0, 64'h13,  2'd0, 64'h0, 64'h55, 1'b0};
    vt[3]  = '{1'b0, 64'h12,  2'd1, 64'h0, 64'h5566, 1'b0};
    vt[4]  = '{1'b1, 64'h10,  2'd0, 64'hFFFFFFFFFFFFFFAB, 64'h0, 1'b0};
    vt[5]  = '{1'b0, 64'h10,  2'd3, 64'h0, 64'h11223344556677AB, 1'b0};
    vt[6]  = '{1'b0, 64'h11,  2'd2, 64'h0, 64'h0, 1'b1};
    vt[7]  = '{1'b0, 64'(MEM - 4), 2'd3, 64'h0, 64'h0, 1'b1};
    vt[8]  = '{1'b1, 64'h11,  2'd2, 64'hFFFFFFFF, 64'h0, 1'b1};
    vt[9]  = '{1'b1, 64'(MEM), 2'd0, 64'h5A, 64'h0, 1'b1};
    vt[10] = '{1'b1, 64'hFFFFFFFFFFFFFFF8, 2'd3, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1};
    vt[11] = '{1'b0, 64'h10,  2'd3, 64'h0, 64'h11223344556677AB, 1'b0};
    vt[12] = '{1'b0, 64'(MEM - 8), 2'd3, 64'h0, 64'h0, 1'b0};
    vt[13] = '{1'b0, 64'h0,   2'd3, 64'h0, 64'h0, 1'b0};
    vt[14] = '{1'b1, 64'(MEM - 2), 2'd1, 64'h1234BEEF, 64'h0, 1'b0};
    vt[15] = '{1'b0, 64'(MEM - 4), 2'd2, 64'h0, 64'hBEEF0000, 1'b0};
    vt[16] = '{1'b0, 64'(MEM - 1), 2'd0, 64'h0, 64'hBE, 1'b0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0; resp_ready = 1'b1;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_size0 = '0; req_wdata0 = '0; resp_ready0 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    check("rst_req_ready0", 64'(req_ready0), 64'd0);
    rst_n = 1'b1;
    #1 check("release_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("first_edge_req_ready", 64'(req_ready), 64'd1);

    zero_fill();
    for (int i = 0; i < 17; i++)
      xact($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].s, vt[i].d, vt[i].rd, vt[i].e, 0);
    xact("hold5", 1'b0, 64'h10, 2'd3, 64'h0, 64'h11223344556677AB, 1'b0, 5);

    zero_fill();
    for (int t = 0; t < 150; t++) begin
      w = 1'($urandom);
      s = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = {$urandom, $urandom};
        1:       a = 64'(MEM - 8 + $urandom_range(0, 15));
        2:       a = 64'($urandom_range(0, MEM - 1));
        default: a = 64'($urandom_range(0, 63)) << s;
      endcase
      d  = {$urandom, $urandom};
      nb = 1 << s;
      e  = ((a % 64'(nb)) != 64'd0) || (a > 64'(MEM - nb));
      exp_rd = '0;
      if (!e) begin
        for (int k = 0; k < nb; k++) begin
          if (w) ref_mem[a + 64'(k)] = d[8*k +: 8];
          else   exp_rd = exp_rd | (64'(ref_mem[a + 64'(k)]) << (8 * k));
        end
      end
      xact("rand", w, a, s, d, exp_rd, e, $urandom_range(0, 2));
    end

    xact("clr20", 1'b1, 64'h20, 2'd3, 64'h0, 64'h0, 1'b0, 0);
    xact("set28", 1'b1, 64'h28, 2'd3, 64'h0123456789ABCDEF, 64'h0, 1'b0, 0);

    // Reset while a load response is being held.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h28; req_size = 2'd3; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_resp_pre_rdata", resp_rdata, 64'h0123456789ABCDEF);
    check("rst_resp_pre_valid", 64'(resp_valid), 64'd1);
    reset_mid_cycle("rst_in_resp");
    resp_ready = 1'b1;

    // Reset while a store is waiting; it must never commit.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_size = 2'd3; req_wdata = 64'hCAFEF00D12345678;
    @(negedge clk);
    req_valid = 1'b0;
    reset_mid_cycle("rst_in_wait");
    xact("rst_load20", 1'b0, 64'h20, 2'd3, 64'h0, 64'h0, 1'b0, 0);

    xact0("z_store", 1'b1, 64'h8, 2'd2, 64'hFFFFFFFFDEADBEEF, 64'h0, 1'b0);
    xact0("z_load_w", 1'b0, 64'h8, 2'd2, 64'h0, 64'hDEADBEEF, 1'b0);
    xact0("z_load_h", 1'b0, 64'hA, 2'd1, 64'h0, 64'hDEAD, 1'b0);
    xact0("z_misalign", 1'b0, 64'h9, 2'd1, 64'h0, 64'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
